// File: rtl/mfp_vga_scanout.sv
// VGA scanout: pixel-rate timing, framebuffer address generation, and a one-pixel
// registered output stage for colour, syncs, vertical blank and the frame interrupt.
module mfp_vga_scanout #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        EN,
  output logic [18:0] IO_VGA_ADDR,
  input  logic [11:0] IO_VGA_DATA,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VBLANK,
  output logic        FRAME_IRQ
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  logic [3:0]    div_q;
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic [18:0]   addr_q;
  logic [11:0]   rgb_q;
  logic          hs_q, vs_q, vblank_q, vblank_dly_q, irq_q;

  logic tick, h_last, v_last, visible, last_pixel, hs_active, vs_active;

  always_comb begin
    tick       = (div_q == 4'(CLK_DIV - 1));
    h_last     = (hcnt_q == HW'(HTotal - 1));
    v_last     = (vcnt_q == VW'(VTotal - 1));
    visible    = (hcnt_q < HW'(H_VISIBLE)) && (vcnt_q < VW'(V_VISIBLE));
    last_pixel = (hcnt_q == HW'(H_VISIBLE - 1)) && (vcnt_q == VW'(V_VISIBLE - 1));
    hs_active  = (hcnt_q >= HW'(H_VISIBLE + H_FP)) && (hcnt_q < HW'(H_VISIBLE + H_FP + H_SYNC));
    vs_active  = (vcnt_q >= VW'(V_VISIBLE + V_FP)) && (vcnt_q < VW'(V_VISIBLE + V_FP + V_SYNC));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addr_q   <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vblank_q <= 1'b0;
    end else if (!EN) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addr_q   <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      div_q <= tick ? 4'd0 : div_q + 4'd1;
      if (tick) begin
        hcnt_q <= h_last ? '0 : hcnt_q + HW'(1);
        if (h_last) begin
          vcnt_q <= v_last ? '0 : vcnt_q + VW'(1);
        end
        // After the last visible pixel the next visible index is 0, so wrap early.
        if ((h_last && v_last) || (visible && last_pixel)) begin
          addr_q <= '0;
        end else if (visible) begin
          addr_q <= addr_q + 19'd1;
        end
        // Output stage reflects the position the counters are leaving.
        rgb_q    <= visible ? IO_VGA_DATA : 12'h000;
        hs_q     <= ~hs_active;
        vs_q     <= ~vs_active;
        vblank_q <= (vcnt_q >= VW'(V_VISIBLE));
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vblank_dly_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      vblank_dly_q <= vblank_q;
      irq_q        <= vblank_q & ~vblank_dly_q;
    end
  end

  assign IO_VGA_ADDR = addr_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VBLANK      = vblank_q;
  assign FRAME_IRQ   = irq_q;

endmodule

// File: tb/tb_mfp_vga_scanout.sv
// Bench for mfp_vga_scanout: three instances (CLK_DIV 4/2/8, memory latency 1/1/7) on a
// reduced raster, checked every cycle against a position-from-elapsed-cycles model.
module tb_mfp_vga_scanout;

  localparam int HV = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VV = 6, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int TOT = HT * VT;
  localparam int NPIX = HV * VV;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [11:0] rom [NPIX];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, inst, $time, got, want);
    end
  endtask

  // Expected outputs after n enabled clock edges: n/c ticks have moved the raster.
  function automatic exp_t model(input int c, input int n);
    exp_t e;
    int   k, p, x, y;
    e = '{addr: 19'd0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, vb: 1'b0};
    k = n / c;
    p = k % TOT;
    x = p % HT;
    y = p / HT;
    if (y < VV) begin
      if (x < HV) e.addr = 19'(y * HV + x);
      else if (y + 1 < VV) e.addr = 19'((y + 1) * HV);
    end
    if (k > 0) begin
      p = (k - 1) % TOT;
      x = p % HT;
      y = p / HT;
      if (x < HV && y < VV) e.rgb = rom[y * HV + x];
      e.hs = !(x >= HV + HFP && x < HV + HFP + HSW);
      e.vs = !(y >= VV + VFP && y < VV + VFP + VSW);
      e.vb = (y >= VV);
    end
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    localparam int L = (g == 2) ? 7 : 1;

    logic [18:0] addr;
    logic [11:0] data;
    logic [3:0]  r, gg, b;
    logic        hs, vs, vb, irq;
    logic [11:0] pipe [L];
    int          n;
    logic        vb1, vb2;
    exp_t        e;

    mfp_vga_scanout #(
      .CLK_DIV(C), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .EN(en), .IO_VGA_ADDR(addr), .IO_VGA_DATA(data),
      .VGA_R(r), .VGA_G(gg), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs), .VBLANK(vb),
      .FRAME_IRQ(irq)
    );

    // Memory with L-cycle read latency.
    always @(posedge clk) begin
      pipe[0] <= (int'(addr) < NPIX) ? rom[int'(addr)] : 12'hbad;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i - 1];
    end
    assign data = pipe[L - 1];

    // Enabled-edge count and a two-deep history of expected VBLANK for the edge detect.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        n   <= 0;
        vb1 <= 1'b0;
        vb2 <= 1'b0;
      end else begin
        n   <= en ? n + 1 : 0;
        vb1 <= model(C, n).vb;
        vb2 <= vb1;
      end
    end

    always @(negedge clk) begin
      e = model(C, n);
      check("addr", g, 32'(addr), 32'(e.addr));
      check("rgb", g, 32'({r, gg, b}), 32'(e.rgb));
      check("sync", g, 32'({hs, vs}), 32'({e.hs, e.vs}));
      check("vblank", g, 32'(vb), 32'(e.vb));
      check("irq", g, 32'(irq), 32'(vb1 & ~vb2));
    end
  end

  int irq_cnt = 0;
  int irq_last = 0;
  int irq_gap = 0;
  always @(negedge clk) begin
    if (g_dut[0].irq) begin
      irq_cnt  <= irq_cnt + 1;
      irq_gap  <= g_dut[0].n - irq_last;
      irq_last <= g_dut[0].n;
    end
  end

  task automatic wait_n(input int target);
    int b = 0;
    while (g_dut[0].n != target && b < 20000) begin
      @(negedge clk);
      b++;
    end
    #1;
    check("wait_bound", 0, 32'(g_dut[0].n), 32'(target));
  endtask

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    for (int i = 0; i < NPIX; i++) rom[i] = 12'($urandom);

    // Reset with EN high, then a long idle stretch with EN low.
    repeat (5) step_in();
    en = 1'b0;
    rst_n = 1'b1;
    base = irq_cnt;
    repeat (10000) step_in();
    check("idle_addr", 0, 32'(g_dut[0].addr), 32'd0);
    check("idle_sync", 0, 32'({g_dut[0].hs, g_dut[0].vs}), 32'b11);
    check("idle_irq_count", 0, 32'(irq_cnt - base), 32'd0);

    // Directed run on instance 0 (CLK_DIV=4).
    en = 1'b1;
    base = irq_cnt;
    wait_n(68);
    check("addr_line0_blank", 0, 32'(g_dut[0].addr), 32'd16);
    wait_n(75);
    check("hs_before_fall", 0, 32'(g_dut[0].hs), 32'd1);
    wait_n(76);
    check("hs_fall", 0, 32'(g_dut[0].hs), 32'd0);
    wait_n(87);
    check("hs_last_low", 0, 32'(g_dut[0].hs), 32'd0);
    wait_n(88);
    check("hs_rise", 0, 32'(g_dut[0].hs), 32'd1);
    wait_n(116);
    check("addr_line1", 0, 32'(g_dut[0].addr), 32'd21);
    wait_n(579);
    check("vblank_before", 0, 32'(g_dut[0].vb), 32'd0);
    wait_n(580);
    check("vblank_rise", 0, 32'({g_dut[0].vb, g_dut[0].irq}), 32'b10);
    wait_n(581);
    check("irq_pulse", 0, 32'(g_dut[0].irq), 32'd1);
    wait_n(582);
    check("irq_single", 0, 32'(g_dut[0].irq), 32'd0);
    wait_n(3 * TOT * 4 + 500);
    check("irq_count_3frames", 0, 32'(irq_cnt - base), 32'd3);
    check("irq_period", 0, 32'(irq_gap), 32'(TOT * 4));

    // Mid-frame asynchronous reset.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", 0, 32'(g_dut[0].addr), 32'd0);
    check("async_rst_out", 0, 32'({g_dut[0].r, g_dut[0].gg, g_dut[0].b, g_dut[0].hs,
                                    g_dut[0].vs, g_dut[0].vb, g_dut[0].irq}), 32'h00000_c);
    repeat (3) step_in();
    rst_n = 1'b1;
    wait_n(76);
    check("hs_fall_after_rst", 0, 32'(g_dut[0].hs), 32'd0);

    // Randomised disturbances: reset pulses at random phases, EN drops, long runs.
    for (int it = 0; it < 20; it++) begin
      int act;
      act = int'($urandom_range(0, 3));
      if (act == 0) begin
        @(posedge clk);
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) step_in();
        rst_n = 1'b1;
      end else if (act == 1) begin
        step_in();
        en = 1'b0;
        repeat ($urandom_range(1, 20)) step_in();
        en = 1'b1;
      end
      repeat ($urandom_range(200, 2400)) step_in();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
